// File: rtl/md_sched.sv
// Multiply/divide sequencing controller: models the MD unit's fixed latency,
// owns the architectural HI/LO registers and raises the MD-collision stall.
module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        d_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORD_W = 32;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [WORD_W-1:0] pend_hi, pend_hi_nxt;
    logic [WORD_W-1:0] pend_lo, pend_lo_nxt;
    logic              pend_ok, pend_ok_nxt;
    logic [WORD_W-1:0] hi_nxt, lo_nxt;
    logic              busy_nxt;

    logic [63:0]       prod_s, prod_u;
    logic [WORD_W-1:0] a_mag, b_mag, b_sdiv, sq_mag, sr_mag, sq, sr;
    logic [WORD_W-1:0] b_udiv, uq, ur;

    // Datapath: products and sign/magnitude division; a zero divisor is
    // replaced by 1 only to keep the dividers well defined (result discarded).
    always_comb begin
        prod_s = {{WORD_W{A[31]}}, A} * {{WORD_W{B[31]}}, B};
        prod_u = {32'd0, A} * {32'd0, B};
        a_mag  = A[31] ? WORD_W'(-A) : A;
        b_mag  = B[31] ? WORD_W'(-B) : B;
        b_sdiv = (b_mag == 32'd0) ? 32'd1 : b_mag;
        sq_mag = a_mag / b_sdiv;
        sr_mag = a_mag % b_sdiv;
        sq     = (A[31] ^ B[31]) ? WORD_W'(-sq_mag) : sq_mag;
        sr     = A[31] ? WORD_W'(-sr_mag) : sr_mag;
        b_udiv = (B == 32'd0) ? 32'd1 : B;
        uq     = A / b_udiv;
        ur     = A % b_udiv;
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_ok_nxt = pend_ok;
        hi_nxt      = hi;
        lo_nxt      = lo;
        case (state)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        3'd0: begin
                            state_nxt   = S_BUSY;
                            cnt_nxt     = CNT_W'(MULT_CYCLES);
                            pend_hi_nxt = prod_s[63:32];
                            pend_lo_nxt = prod_s[31:0];
                            pend_ok_nxt = 1'b1;
                        end
                        3'd1: begin
                            state_nxt   = S_BUSY;
                            cnt_nxt     = CNT_W'(MULT_CYCLES);
                            pend_hi_nxt = prod_u[63:32];
                            pend_lo_nxt = prod_u[31:0];
                            pend_ok_nxt = 1'b1;
                        end
                        3'd2: begin
                            state_nxt   = S_BUSY;
                            cnt_nxt     = CNT_W'(DIV_CYCLES);
                            pend_hi_nxt = sr;
                            pend_lo_nxt = sq;
                            pend_ok_nxt = (B != 32'd0);
                        end
                        3'd3: begin
                            state_nxt   = S_BUSY;
                            cnt_nxt     = CNT_W'(DIV_CYCLES);
                            pend_hi_nxt = ur;
                            pend_lo_nxt = uq;
                            pend_ok_nxt = (B != 32'd0);
                        end
                        3'd4:    hi_nxt = A;
                        3'd5:    lo_nxt = A;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                // Starts arriving while busy are dropped; only the counter advances.
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                    if (pend_ok) begin
                        hi_nxt = pend_hi;
                        lo_nxt = pend_lo;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt == S_BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_ok <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_ok <= pend_ok_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
            busy    <= busy_nxt;
        end
    end

    // Hold the ID-stage MD instruction while the unit is or is about to be busy.
    assign stall = d_md & (busy | (start & ~op[2]));

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: a transaction-level HI/LO model is compared
// against the DUT every cycle, plus literal expectations from hand arithmetic.
module tb_md_sched;
    localparam int unsigned MULT_N = 5;
    localparam int unsigned DIV_N  = 10;

    logic        clk = 1'b0;
    logic        rst, start, d_md;
    logic [2:0]  op;
    logic [31:0] A, B;
    logic        busy, stall;
    logic [31:0] hi, lo;

    md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .d_md(d_md), .busy(busy), .stall(stall), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned busy_cnt = 0;
    int unsigned stall_cnt = 0;

    // Model state: completion is scheduled at an absolute edge number.
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [63:0] m_pend = '0;
    logic        m_ok = 1'b0, m_active = 1'b0;
    int          m_edge = 0, m_done = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk32(name, {31'd0, act}, {31'd0, exp});
    endtask

    // {write_enable, hi, lo} that an MD op must eventually produce.
    function automatic logic [64:0] model_res(input logic [2:0] o, input logic [31:0] av,
                                              input logic [31:0] bv);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (o)
            3'd0: begin q = sa * sb; p = q; return {1'b1, p}; end
            3'd1: begin p = 64'(av) * 64'(bv); return {1'b1, p}; end
            3'd2: begin
                if (bv == 32'd0) return '0;
                q = sa / sb;
                r = sa % sb;
                return {1'b1, r[31:0], q[31:0]};
            end
            default: begin
                if (bv == 32'd0) return '0;
                return {1'b1, av % bv, av / bv};
            end
        endcase
    endfunction

    task automatic do_cycle(input logic r, input logic s, input logic [2:0] o,
                            input logic [31:0] av, input logic [31:0] bv, input logic d);
        logic [64:0] res;
        rst = r; start = s; op = o; A = av; B = bv; d_md = d;
        #1;
        chk1("stall", stall, d && (m_active || (s && o < 3'd4)));
        if (stall === 1'b1) stall_cnt++;
        @(posedge clk);
        m_edge++;
        if (r) begin
            m_hi = '0; m_lo = '0; m_active = 1'b0; m_ok = 1'b0;
        end else if (m_active) begin
            if (m_edge == m_done) begin
                if (m_ok) begin m_hi = m_pend[63:32]; m_lo = m_pend[31:0]; end
                m_active = 1'b0;
            end
        end else if (s) begin
            if (o < 3'd4) begin
                res      = model_res(o, av, bv);
                m_ok     = res[64];
                m_pend   = res[63:0];
                m_active = 1'b1;
                m_done   = m_edge + ((o < 3'd2) ? int'(MULT_N) : int'(DIV_N));
            end else if (o == 3'd4) m_hi = av;
            else if (o == 3'd5) m_lo = av;
        end
        @(negedge clk);
        chk1("busy", busy, m_active);
        chk32("hi", hi, m_hi);
        chk32("lo", lo, m_lo);
        if (busy === 1'b1) busy_cnt++;
    endtask

    task automatic idle(input int n, input logic d);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 3'd6, 32'd0, 32'd0, d);
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic d);
        busy_cnt = 0; stall_cnt = 0;
        do_cycle(1'b0, 1'b1, o, av, bv, d);
    endtask

    initial begin
        do_cycle(1'b1, 1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
        do_cycle(1'b1, 1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
        chk32("reset_hi", hi, 32'd0);
        chk32("reset_lo", lo, 32'd0);
        chk1("reset_busy", busy, 1'b0);

        // MULT -2 * 3
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        idle(6, 1'b0);
        chk32("mult_busy_len", busy_cnt, 32'd5);
        chk32("mult_hi", hi, 32'hFFFF_FFFF);
        chk32("mult_lo", lo, 32'hFFFF_FFFA);

        // DIVU 100/7 with an MD instruction held in ID
        issue(3'd3, 32'd100, 32'd7, 1'b1);
        idle(11, 1'b1);
        chk32("divu_busy_len", busy_cnt, 32'd10);
        chk32("divu_stall_len", stall_cnt, 32'd11);
        chk32("divu_lo", lo, 32'd14);
        chk32("divu_hi", hi, 32'd2);

        // DIV sign rules
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(10, 1'b0);
        chk32("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk32("div_neg_hi", hi, 32'hFFFF_FFFF);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(10, 1'b0);
        chk32("div_ovf_lo", lo, 32'h8000_0000);
        chk32("div_ovf_hi", hi, 32'd0);

        // MTHI/MTLO then divide by zero preserves HI/LO
        issue(3'd4, 32'h11, 32'd0, 1'b0);
        do_cycle(1'b0, 1'b1, 3'd5, 32'h22, 32'd0, 1'b0);
        chk32("mt_busy", busy_cnt, 32'd0);
        issue(3'd2, 32'd5, 32'd0, 1'b0);
        idle(10, 1'b0);
        chk32("div0_busy_len", busy_cnt, 32'd10);
        chk32("div0_hi", hi, 32'h11);
        chk32("div0_lo", lo, 32'h22);

        issue(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0);
        chk32("mthi", hi, 32'hDEAD_BEEF);
        do_cycle(1'b0, 1'b1, 3'd5, 32'h1234, 32'd0, 1'b0);
        chk32("mtlo", lo, 32'h1234);
        chk32("mt2_busy", busy_cnt, 32'd0);
        do_cycle(1'b0, 1'b1, 3'd7, 32'h5555, 32'h6666, 1'b1);
        chk32("noop_hi", hi, 32'hDEAD_BEEF);

        // Reset on the third busy cycle of a MULTU
        issue(3'd1, 32'h0001_0000, 32'h0003_0000, 1'b0);
        idle(2, 1'b0);
        do_cycle(1'b1, 1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
        chk1("rst_mid_busy", busy, 1'b0);
        chk32("rst_mid_hi", hi, 32'd0);
        chk32("rst_mid_lo", lo, 32'd0);
        idle(5, 1'b0);
        chk32("rst_late_hi", hi, 32'd0);

        // Reset and start on the same edge: reset wins
        busy_cnt = 0;
        do_cycle(1'b1, 1'b1, 3'd0, 32'd9, 32'd9, 1'b0);
        idle(2, 1'b0);
        chk32("rst_start_busy", busy_cnt, 32'd0);
        chk32("rst_start_lo", lo, 32'd0);

        // Second start on busy cycle 4 of a DIV is ignored
        issue(3'd2, 32'd100, 32'hFFFF_FFF9, 1'b0);
        idle(3, 1'b0);
        do_cycle(1'b0, 1'b1, 3'd0, 32'd3, 32'd4, 1'b0);
        idle(7, 1'b0);
        chk32("ovl_busy_len", busy_cnt, 32'd10);
        chk32("ovl_lo", lo, 32'hFFFF_FFF2);
        chk32("ovl_hi", hi, 32'd2);
        idle(3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
